// File: rtl/fmap_pkg.sv
// fmap_pkg: shared state encoding, bank sizing and length clamp for the feature-map controller
package fmap_pkg;
    localparam int FMAP_BANK_DEPTH = 4096;
    localparam int FMAP_ADDR_WIDTH = 13;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fmap_state_t;
    function automatic logic [12:0] clamp_len(input logic [12:0] len);
        return (len > 13'(FMAP_BANK_DEPTH)) ? 13'(FMAP_BANK_DEPTH) : len;
    endfunction
endpackage

// File: rtl/fmap_rd_pipe.sv
// fmap_rd_pipe: read-latency valid shift register with synchronous flush and empty flag
module fmap_rd_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic flush,
    input  logic issue,
    output logic valid,
    output logic empty
);
    logic [LAT-1:0] sr;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sr <= '0;
        else       sr <= flush ? '0 : (sr << 1) | LAT'(issue);
    end
    // a flushed word must not appear even in the flush cycle itself
    assign valid = sr[LAT-1] & ~flush;
    assign empty = ~|sr;
endmodule

// File: rtl/fmap_addr_ctrl.sv
// fmap_addr_ctrl: ping-pong read/write address sequencer for the 2x4096-word feature-map memory
// Define FMAP_STALL_CNT_EN to add the stall_cnt output.
module fmap_addr_ctrl
    import fmap_pkg::*;
#(
    parameter int ADDR_WIDTH = FMAP_ADDR_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  state_rst,
    input  logic [2:0]            current_state,
    input  logic [12:0]           rd_len,
    input  logic [12:0]           wr_len,
    input  logic                  rd_ready,
    input  logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  layer_done,
    output logic [2:0]            layer_tag,
    output logic                  err_overflow,
    output logic                  bank
`ifdef FMAP_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);
    fmap_state_t state, state_nxt;
    logic [12:0] rd_cnt, wr_cnt, rd_lim, wr_lim, rd_cnt_nxt, wr_cnt_nxt;
    logic [ADDR_WIDTH-2:0] wr_off;
    logic active, wr_acc, pipe_empty;

    assign active     = state == READ || state == DRAIN;
    assign wr_acc     = wr_en && active && wr_cnt < wr_lim;
    assign rd_cnt_nxt = rd_cnt + 13'(rd_en);
    assign wr_cnt_nxt = wr_cnt + 13'(wr_acc);
    // once the write count is exhausted the address stays on the last word written
    assign wr_off  = (wr_cnt < wr_lim || wr_cnt == '0) ? wr_cnt[ADDR_WIDTH-2:0]
                                                       : wr_cnt[ADDR_WIDTH-2:0] - (ADDR_WIDTH-1)'(1);
    assign rd_addr = {bank, rd_cnt[ADDR_WIDTH-2:0]};
    assign wr_addr = {~bank, wr_off};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state_rst ? (clamp_len(rd_len) == '0 ? DRAIN : READ) :
                    (state == READ && rd_cnt_nxt >= rd_lim) ? DRAIN :
                    (state == DRAIN && pipe_empty && wr_cnt_nxt == wr_lim) ? DONE :
                    (state == DONE) ? IDLE : state;
    end

    always_comb begin
        rd_en      = state == READ && !state_rst && rd_ready && rd_cnt < rd_lim;
        layer_done = state == DONE && !state_rst;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            rd_lim       <= '0;
            wr_lim       <= '0;
            layer_tag    <= '0;
            bank         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_overflow <= err_overflow | (wr_en & ~wr_acc);
            bank         <= bank ^ layer_done;
            if (state_rst) begin
                rd_cnt    <= '0;
                wr_cnt    <= '0;
                rd_lim    <= clamp_len(rd_len);
                wr_lim    <= clamp_len(wr_len);
                layer_tag <= current_state;
            end else begin
                rd_cnt <= rd_cnt_nxt;
                wr_cnt <= wr_cnt_nxt;
            end
        end
    end

    fmap_rd_pipe #(.LAT(RD_LATENCY)) u_rd_pipe (
        .clk   (clk),
        .rstn  (rstn),
        .flush (state_rst),
        .issue (rd_en),
        .valid (rd_valid),
        .empty (pipe_empty)
    );

`ifdef FMAP_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          stall_cnt <= '0;
        else if (state_rst) stall_cnt <= '0;
        else if (state == READ && !rd_ready && rd_cnt < rd_lim && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fmap_addr_ctrl.sv
// tb_fmap_addr_ctrl: directed vector bench for fmap_addr_ctrl
module tb_fmap_addr_ctrl;
    logic clk = 1'b0, rstn = 1'b0, state_rst = 1'b0, rd_ready = 1'b0, wr_en = 1'b0;
    logic [2:0] current_state = 3'd0;
    logic [12:0] rd_len = '0, wr_len = '0;
    logic [12:0] rd_addr, wr_addr;
    logic rd_en, rd_valid, layer_done, err_overflow, bank;
    logic [2:0] layer_tag;
`ifdef FMAP_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int checks = 0, errors = 0;
    int p, n;
    int rdy_pat[5] = '{1, 0, 1, 0, 1};

    typedef struct {
        logic s;
        logic [12:0] rl, wl;
        logic r, w;
        logic en;
        logic [12:0] ra;
        logic v;
        logic [12:0] wa;
        logic d, b;
    } vec_t;
    vec_t tv[15];

    always #5 clk = ~clk;

    fmap_addr_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .state_rst     (state_rst),
        .current_state (current_state),
        .rd_len        (rd_len),
        .wr_len        (wr_len),
        .rd_ready      (rd_ready),
        .wr_en         (wr_en),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .rd_valid      (rd_valid),
        .wr_addr       (wr_addr),
        .layer_done    (layer_done),
        .layer_tag     (layer_tag),
        .err_overflow  (err_overflow),
        .bank          (bank)
`ifdef FMAP_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    function automatic vec_t mk(input int s, rl, wl, r, w, en, ra, v, wa, d, b);
        vec_t t;
        t.s = 1'(s); t.rl = 13'(rl); t.wl = 13'(wl); t.r = 1'(r); t.w = 1'(w);
        t.en = 1'(en); t.ra = 13'(ra); t.v = 1'(v); t.wa = 13'(wa); t.d = 1'(d); t.b = 1'(b);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, rl, wl, r, w);
        state_rst = 1'(s);
        rd_len    = 13'(rl);
        wr_len    = 13'(wl);
        rd_ready  = 1'(r);
        wr_en     = 1'(w);
        #3;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            next_cyc();
            #3;
            if (layer_done) pulses++;
        end
    endtask

    initial begin
        // two back-to-back layers: bank 0 then bank 1
        tv[0]  = mk(1, 4, 2, 1, 0, 0, 'h0000, 0, 'h1000, 0, 0);
        tv[1]  = mk(0, 4, 2, 1, 1, 1, 'h0000, 0, 'h1000, 0, 0);
        tv[2]  = mk(0, 4, 2, 1, 0, 1, 'h0001, 1, 'h1001, 0, 0);
        tv[3]  = mk(0, 4, 2, 1, 1, 1, 'h0002, 1, 'h1001, 0, 0);
        tv[4]  = mk(0, 4, 2, 1, 0, 1, 'h0003, 1, 'h1001, 0, 0);
        tv[5]  = mk(0, 4, 2, 1, 0, 0, 'h0004, 1, 'h1001, 0, 0);
        tv[6]  = mk(0, 4, 2, 1, 0, 0, 'h0004, 0, 'h1001, 0, 0);
        tv[7]  = mk(0, 4, 2, 1, 0, 0, 'h0004, 0, 'h1001, 1, 0);
        tv[8]  = mk(1, 2, 1, 1, 0, 0, 'h1004, 0, 'h0001, 0, 1);
        tv[9]  = mk(0, 2, 1, 1, 1, 1, 'h1000, 0, 'h0000, 0, 1);
        tv[10] = mk(0, 2, 1, 1, 0, 1, 'h1001, 1, 'h0000, 0, 1);
        tv[11] = mk(0, 2, 1, 1, 0, 0, 'h1002, 1, 'h0000, 0, 1);
        tv[12] = mk(0, 2, 1, 1, 0, 0, 'h1002, 0, 'h0000, 0, 1);
        tv[13] = mk(0, 2, 1, 1, 0, 0, 'h1002, 0, 'h0000, 1, 1);
        tv[14] = mk(0, 2, 1, 1, 0, 0, 'h0002, 0, 'h1000, 0, 0);

        #3;
        chk("rst_rd_addr", 32'(rd_addr), 'h0000);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_wr_addr", 32'(wr_addr), 'h1000);
        chk("rst_layer_done", 32'(layer_done), 0);
        chk("rst_layer_tag", 32'(layer_tag), 0);
        chk("rst_err", 32'(err_overflow), 0);
        chk("rst_bank", 32'(bank), 0);
        next_cyc();
        rstn = 1'b1;
        current_state = 3'd5;

        for (int i = 0; i < 15; i++) begin
            drive(tv[i].s, tv[i].rl, tv[i].wl, tv[i].r, tv[i].w);
            chk($sformatf("v%0d_rd_en", i), 32'(rd_en), 32'(tv[i].en));
            chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(tv[i].ra));
            chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(tv[i].v));
            chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(tv[i].wa));
            chk($sformatf("v%0d_done", i), 32'(layer_done), 32'(tv[i].d));
            chk($sformatf("v%0d_bank", i), 32'(bank), 32'(tv[i].b));
            if (i < 14) next_cyc();
        end
        chk("tbl_tag", 32'(layer_tag), 5);
        chk("tbl_err", 32'(err_overflow), 0);

        // rd_ready toggling: reads only on ready cycles, no address skips
        next_cyc();
        current_state = 3'd6;
        drive(1, 3, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            drive(0, 3, 0, rdy_pat[i], 0);
            chk($sformatf("t3_rd_en%0d", i), 32'(rd_en), 32'(rdy_pat[i]));
            if (rdy_pat[i] != 0) begin
                chk($sformatf("t3_rd_addr%0d", i), 32'(rd_addr), 32'(n));
                n++;
            end
        end
        chk("t3_tag", 32'(layer_tag), 6);
        window(8, p);
        chk("t3_done_pulses", 32'(p), 1);
        chk("t3_bank", 32'(bank), 1);
`ifdef FMAP_STALL_CNT_EN
        chk("t3_stall_cnt", 32'(stall_cnt), 2);
`endif

        // abort mid-READ after two of eight reads
        next_cyc();
        drive(1, 8, 0, 0, 0);
        next_cyc();
        drive(0, 8, 0, 1, 0);
        chk("t5_rd_addr0", 32'(rd_addr), 'h1000);
        next_cyc();
        drive(0, 8, 0, 1, 0);
        chk("t5_rd_addr1", 32'(rd_addr), 'h1001);
        next_cyc();
        drive(1, 2, 0, 1, 0);
        chk("t5_flush_valid", 32'(rd_valid), 0);
        chk("t5_abort_done", 32'(layer_done), 0);
        next_cyc();
        drive(0, 2, 0, 1, 0);
        chk("t5_restart_addr", 32'(rd_addr), 'h1000);
        chk("t5_restart_en", 32'(rd_en), 1);
        chk("t5_stray_valid", 32'(rd_valid), 0);
        chk("t5_bank_kept", 32'(bank), 1);
        window(8, p);
        chk("t5_done_pulses", 32'(p), 1);
        chk("t5_bank", 32'(bank), 0);

        // write overflow with wr_len = 1
        next_cyc();
        drive(1, 3, 1, 0, 0);
        next_cyc();
        drive(0, 3, 1, 0, 1);
        chk("t4_wr_addr0", 32'(wr_addr), 'h1000);
        chk("t4_err0", 32'(err_overflow), 0);
        next_cyc();
        drive(0, 3, 1, 0, 1);
        chk("t4_wr_addr1", 32'(wr_addr), 'h1000);
        chk("t4_err1", 32'(err_overflow), 0);
        next_cyc();
        drive(0, 3, 1, 0, 1);
        chk("t4_wr_addr2", 32'(wr_addr), 'h1000);
        chk("t4_err2", 32'(err_overflow), 1);
        next_cyc();
        drive(0, 3, 1, 1, 0);
        chk("t4_err3", 32'(err_overflow), 1);
        window(10, p);
        chk("t4_done_pulses", 32'(p), 1);
        chk("t4_err_sticky", 32'(err_overflow), 1);
        chk("t4_bank", 32'(bank), 1);

        // zero-length layer: DRAIN then DONE two cycles after state_rst
        next_cyc();
        drive(1, 0, 0, 1, 0);
        chk("t6_done_c0", 32'(layer_done), 0);
        next_cyc();
        drive(0, 0, 0, 1, 0);
        chk("t6_rd_en_c1", 32'(rd_en), 0);
        chk("t6_done_c1", 32'(layer_done), 0);
        next_cyc();
        drive(0, 0, 0, 1, 0);
        chk("t6_rd_en_c2", 32'(rd_en), 0);
        chk("t6_done_c2", 32'(layer_done), 1);
        next_cyc();
        drive(0, 0, 0, 1, 0);
        chk("t6_done_c3", 32'(layer_done), 0);
        chk("t6_bank", 32'(bank), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
